cabac_bin_engine: RTL and testbench
===================================

# cabac_bin_engine

Sequencing controller for the VVC arithmetic-decoder datapath. It owns the 9-bit range and offset registers and accepts bin-decode requests (regular, bypass, terminate) from the context modeller. It drives the getLPS unit for regular bins, pulls bitstream bits one at a time over a valid/ready handshake during initialisation and renormalisation, and returns one decoded bin per request.

## Interface
- No parameters; all widths are fixed by the VVC arithmetic decoding process.
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- init  in  1  one-cycle pulse: start a slice (load range, read 9 offset bits); honoured in every state
- bit_in  in  1  next bitstream bit, MSB-first
- bit_valid  in  1  bit_in is valid
- bit_ready  out  1  engine consumes bit_in this cycle when bit_valid=1
- req_valid  in  1  bin request valid
- req_mode  in  2  00 regular, 01 bypass, 10 terminate, 11 reserved (treated as bypass)
- req_state  in  8  context probability state; bit 7 is the MPS value
- req_ready  out  1  high only in READY
- bin_valid  out  1  one-cycle pulse: bin_val is valid
- bin_val  out  1  decoded bin; holds its value until the next bin_valid
- slice_end  out  1  pulses with bin_valid when a terminate bin decodes to 1
- busy  out  1  high in every state except IDLE and READY
- cur_range  out  9  range register; cur_offset out 9 offset register (observation only)

## Operation
- States: IDLE, INIT, READY, SHIFT, DECIDE, RENORM.
- Reset values: state=IDLE, range=510, offset=0, all handshake and strobe outputs 0, bin_val=0.
- IDLE: waits for init. init in any state: range←510, offset←0, bit count←0, go to INIT. init aborts any request in flight, and that request produces no bin_valid.
- INIT: bit_ready=1. Each accepted bit does offset←{offset[7:0],bit}. After 9 bits, go to READY.
- READY: req_ready=1. On handshake, latch mode and state. Regular or terminate goes to DECIDE; bypass goes to SHIFT.
- SHIFT (bypass only): bit_ready=1. On an accepted bit, t={offset,bit} (10 bits). If t≥{0,range}: bin=1, offset←t−range; else bin=0, offset←t[8:0]. Go to READY and pulse bin_valid.
- DECIDE, regular mode:
  - rLPS is the getLPS output: q = state[7] ? state^0xFF : state; rLPS = (((q>>2)*(range>>5))>>1)+4. rLPS stays within 8 bits because its maximum is 236.
  - rMPS = range−rLPS, mps = state[7].
  - If offset≥rMPS: bin=!mps, offset←offset−rMPS, range←rLPS.
  - Else: bin=mps, range←rMPS.
- DECIDE, terminate mode: range←range−2.
  - If offset≥range−2: bin=1, pulse slice_end, go to IDLE with no renormalisation.
  - Else: bin=0.
- After DECIDE: if the new range<256, go to RENORM; otherwise go to READY with bin_valid.
- RENORM: bit_ready=1. Each accepted bit does range←range<<1, offset←{offset[7:0],bit}. Repeat while range<256, then go to READY with bin_valid. A regular LPS needs at most 6 bits; terminate needs at most 1.
- Invariants: offset<range at all times; 256≤range≤510 in READY.

## Timing
- Request accepted at cycle T:
  - Regular or terminate with no renorm: bin_valid and req_ready both high at T+2.
  - Each renorm bit adds one cycle per accepted bit.
  - Bypass: bin_valid at the cycle after the bit is accepted, i.e. earliest T+2.
- bit_valid low stalls INIT, SHIFT and RENORM indefinitely with no state change. bit_ready is combinational from state only.
- bin_valid, bin_val and slice_end are registered and asserted in the first READY (or IDLE) cycle. A new request may be accepted in that same cycle.
- init coincident with req_valid in READY: init wins, and the request is not accepted (req_ready is forced low).
- rst_n asserted mid-operation returns everything to reset values immediately; bits already consumed are lost.

## Test plan
- Init, bits 100101100 → offset=300, range=510, req_ready after 9 accepted bits (bin_valid stays low).
- Regular, state=0x00, range 510, offset 300 → rLPS=4, bin=0, range=506, offset 300, bin_valid at T+2, no bits consumed.
- Regular, state=0x7F, range 510, offset 300 → rLPS=236, bin=1 (LPS), offset=26, one renorm bit=1 → range=472, offset=53.
- Bypass, range 510, offset 300, bit=1 → bin=1, offset=91; repeat with bit_valid held low 5 cycles → no state change, bin_valid delayed 5 cycles.
- Terminate: range 510, offset 300 → bin=0, range=508, no bits consumed. Re-init with offset=508 (111111100), then terminate → bin=1, slice_end=1, state IDLE, req_ready=0.
- init pulse during RENORM, and rst_n low during INIT → no bin_valid, clean 9-bit re-init, and range=510/offset=0 while reset is held.

Source files
------------

// File: rtl/cabac_bin_if.sv
// cabac_bin_if: bitstream, bin-request and bin-result signals of the CABAC bin engine.
interface cabac_bin_if;
    logic       init;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       req_valid;
    logic [1:0] req_mode;
    logic [7:0] req_state;
    logic       req_ready;
    logic       bin_valid;
    logic       bin_val;
    logic       slice_end;
    logic       busy;
    logic [8:0] cur_range;
    logic [8:0] cur_offset;

    modport master (
        output init, bit_in, bit_valid, req_valid, req_mode, req_state,
        input  bit_ready, req_ready, bin_valid, bin_val, slice_end, busy, cur_range, cur_offset
    );

    modport slave (
        input  init, bit_in, bit_valid, req_valid, req_mode, req_state,
        output bit_ready, req_ready, bin_valid, bin_val, slice_end, busy, cur_range, cur_offset
    );
endinterface

// File: rtl/cabac_bin_engine.sv
// cabac_bin_engine: VVC arithmetic-decoder sequencer owning range/offset, decoding
// regular, bypass and terminate bins and pulling bitstream bits for init and renorm.
module cabac_bin_engine (
    input  logic        clk,
    input  logic        rst_n,
    cabac_bin_if.slave  eng
);
    typedef enum logic [2:0] {IDLE, INIT, READY, SHIFT, DECIDE, RENORM} state_e;

    state_e     state_q, state_d;
    logic [8:0] range_q, range_d;
    logic [8:0] offset_q, offset_d;
    logic [3:0] cnt_q, cnt_d;
    logic       term_q, term_d;
    logic [7:0] ctx_q, ctx_d;
    logic       pend_q, pend_d;
    logic       bin_valid_q, bin_valid_d;
    logic       bin_val_q, bin_val_d;
    logic       slice_end_q, slice_end_d;

    // getLPS: fold the state onto its LPS half, then scale by the range quadrant
    logic [4:0] q;
    logic [8:0] prod, rlps, rmps, trm, dec_range, dec_off;
    logic       lps, dec_bin;
    logic [9:0] t;
    logic       t_ge;

    assign q         = ctx_q[7] ? ~ctx_q[6:2] : ctx_q[6:2];
    assign prod      = {4'b0, q} * {5'b0, range_q[8:5]};
    assign rlps      = (prod >> 1) + 9'd4;
    assign rmps      = range_q - rlps;
    assign trm       = range_q - 9'd2;
    assign lps       = offset_q >= rmps;
    assign dec_range = term_q ? trm : (lps ? rlps : rmps);
    assign dec_bin   = term_q ? (offset_q >= trm) : (lps ^ ctx_q[7]);
    assign dec_off   = (!term_q && lps) ? offset_q - rmps : offset_q;
    assign t         = {offset_q, eng.bit_in};
    assign t_ge      = t >= {1'b0, range_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            range_q     <= 9'd510;
            offset_q    <= 9'd0;
            cnt_q       <= 4'd0;
            term_q      <= 1'b0;
            ctx_q       <= 8'd0;
            pend_q      <= 1'b0;
            bin_valid_q <= 1'b0;
            bin_val_q   <= 1'b0;
            slice_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            range_q     <= range_d;
            offset_q    <= offset_d;
            cnt_q       <= cnt_d;
            term_q      <= term_d;
            ctx_q       <= ctx_d;
            pend_q      <= pend_d;
            bin_valid_q <= bin_valid_d;
            bin_val_q   <= bin_val_d;
            slice_end_q <= slice_end_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        range_d     = range_q;
        offset_d    = offset_q;
        cnt_d       = cnt_q;
        term_d      = term_q;
        ctx_d       = ctx_q;
        pend_d      = pend_q;
        bin_valid_d = 1'b0;
        bin_val_d   = bin_val_q;
        slice_end_d = 1'b0;
        if (eng.init) begin
            state_d  = INIT;
            range_d  = 9'd510;
            offset_d = 9'd0;
            cnt_d    = 4'd0;
        end else begin
            case (state_q)
                INIT: if (eng.bit_valid) begin
                    offset_d = {offset_q[7:0], eng.bit_in};
                    cnt_d    = cnt_q + 4'd1;
                    state_d  = (cnt_q == 4'd8) ? READY : INIT;
                end
                READY: if (eng.req_valid) begin
                    term_d  = eng.req_mode[1];
                    ctx_d   = eng.req_state;
                    state_d = eng.req_mode[0] ? SHIFT : DECIDE;
                end
                SHIFT: if (eng.bit_valid) begin
                    offset_d    = t_ge ? t[8:0] - range_q : t[8:0];
                    bin_val_d   = t_ge;
                    bin_valid_d = 1'b1;
                    state_d     = READY;
                end
                DECIDE: begin
                    range_d  = dec_range;
                    offset_d = dec_off;
                    pend_d   = dec_bin;
                    // terminate-with-1 ends the slice without renormalising
                    if ((term_q && dec_bin) || dec_range[8]) begin
                        bin_val_d   = dec_bin;
                        bin_valid_d = 1'b1;
                        slice_end_d = term_q && dec_bin;
                        state_d     = (term_q && dec_bin) ? IDLE : READY;
                    end else begin
                        state_d = RENORM;
                    end
                end
                RENORM: if (eng.bit_valid) begin
                    range_d  = {range_q[7:0], 1'b0};
                    offset_d = {offset_q[7:0], eng.bit_in};
                    if (range_q[7]) begin
                        bin_val_d   = pend_q;
                        bin_valid_d = 1'b1;
                        state_d     = READY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        eng.bit_ready  = (state_q == INIT) || (state_q == SHIFT) || (state_q == RENORM);
        eng.req_ready  = (state_q == READY) && !eng.init;
        eng.busy       = (state_q != IDLE) && (state_q != READY);
        eng.bin_valid  = bin_valid_q;
        eng.bin_val    = bin_val_q;
        eng.slice_end  = slice_end_q;
        eng.cur_range  = range_q;
        eng.cur_offset = offset_q;
    end
endmodule

// File: tb/tb_cabac_bin_engine.sv
// tb_cabac_bin_engine: directed vectors with hand-computed range/offset/bin results
// for init, regular, bypass and terminate decoding, plus init/reset aborts.
module tb_cabac_bin_engine;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail = 0;
    int   bv_cnt = 0;
    int   bit_cnt = 0;
    int   lat, b0, v0;

    always #5 clk = ~clk;

    cabac_bin_if bif();

    cabac_bin_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .eng   (bif.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // count bits the upcoming edge accepts, advance, then count bin pulses
    task automatic tick();
        if (!bif.init && bif.bit_valid && bif.bit_ready) bit_cnt++;
        @(negedge clk);
        if (bif.bin_valid) bv_cnt++;
    endtask

    task automatic feed_bits(input logic [8:0] b);
        for (int i = 8; i >= 0; i--) begin
            bif.bit_in    = b[i];
            bif.bit_valid = 1'b1;
            tick();
        end
        bif.bit_valid = 1'b0;
    endtask

    task automatic init_bits(input logic [8:0] b);
        bif.init = 1'b1;
        tick();
        bif.init = 1'b0;
        feed_bits(b);
    endtask

    task automatic request(input logic [1:0] m, input logic [7:0] s);
        bif.req_mode  = m;
        bif.req_state = s;
        bif.req_valid = 1'b1;
        tick();
        bif.req_valid = 1'b0;
    endtask

    // lat counts cycles after the accepting edge; bits are offered after `stall` cycles
    task automatic wait_bin(input int stall, input int hold_off, output int l);
        l = 1;
        while (!bif.bin_valid && l < 20) begin
            bif.bit_valid = (l > stall);
            if (stall > 0 && l == stall) check("stall_offset", bif.cur_offset, hold_off);
            tick();
            l++;
        end
        bif.bit_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bif.init = 1'b0;
        bif.bit_in = 1'b0;
        bif.bit_valid = 1'b0;
        bif.req_valid = 1'b0;
        bif.req_mode = 2'b00;
        bif.req_state = 8'd0;
        tick();
        tick();
        check("rst_range", bif.cur_range, 510);
        check("rst_offset", bif.cur_offset, 0);
        check("rst_req_ready", bif.req_ready, 0);
        check("rst_bit_ready", bif.bit_ready, 0);
        check("rst_busy", bif.busy, 0);
        check("rst_bin_valid", bif.bin_valid, 0);
        check("rst_bin_val", bif.bin_val, 0);
        check("rst_slice_end", bif.slice_end, 0);
        rst_n = 1'b1;
        tick();

        init_bits(9'b100101100);
        check("init_offset", bif.cur_offset, 300);
        check("init_range", bif.cur_range, 510);
        check("init_req_ready", bif.req_ready, 1);
        check("init_busy", bif.busy, 0);
        check("init_bits", bit_cnt, 9);
        check("init_no_bin", bv_cnt, 0);

        b0 = bit_cnt;
        request(2'b00, 8'h00);
        wait_bin(0, 0, lat);
        check("reg00_lat", lat, 2);
        check("reg00_bin", bif.bin_val, 0);
        check("reg00_range", bif.cur_range, 506);
        check("reg00_offset", bif.cur_offset, 300);
        check("reg00_req_ready", bif.req_ready, 1);
        check("reg00_bits", bit_cnt - b0, 0);

        init_bits(9'b100101100);
        b0 = bit_cnt;
        bif.bit_in = 1'b1;
        request(2'b01, 8'h00);
        wait_bin(0, 0, lat);
        check("byp_lat", lat, 2);
        check("byp_bin", bif.bin_val, 1);
        check("byp_offset", bif.cur_offset, 91);
        check("byp_range", bif.cur_range, 510);
        check("byp_bits", bit_cnt - b0, 1);

        init_bits(9'b100101100);
        b0 = bit_cnt;
        bif.bit_in = 1'b0;
        request(2'b00, 8'h80);
        wait_bin(0, 0, lat);
        check("reg80_lat", lat, 3);
        check("reg80_bin", bif.bin_val, 0);
        check("reg80_range", bif.cur_range, 472);
        check("reg80_offset", bif.cur_offset, 52);
        check("reg80_bits", bit_cnt - b0, 1);

        init_bits(9'b100101100);
        bif.bit_in = 1'b0;
        request(2'b11, 8'h00);
        wait_bin(0, 0, lat);
        check("rsv_lat", lat, 2);
        check("rsv_bin", bif.bin_val, 1);
        check("rsv_offset", bif.cur_offset, 90);

        init_bits(9'b100101100);
        b0 = bit_cnt;
        request(2'b10, 8'h00);
        wait_bin(0, 0, lat);
        check("term0_lat", lat, 2);
        check("term0_bin", bif.bin_val, 0);
        check("term0_slice_end", bif.slice_end, 0);
        check("term0_range", bif.cur_range, 508);
        check("term0_offset", bif.cur_offset, 300);
        check("term0_bits", bit_cnt - b0, 0);

        init_bits(9'b100101100);
        bif.bit_in = 1'b1;
        request(2'b01, 8'h00);
        wait_bin(5, 300, lat);
        check("stall_lat", lat, 7);
        check("stall_bin", bif.bin_val, 1);
        check("stall_offset_after", bif.cur_offset, 91);

        init_bits(9'b100101100);
        b0 = bit_cnt;
        bif.bit_in = 1'b1;
        request(2'b00, 8'h7F);
        wait_bin(0, 0, lat);
        check("reg7f_lat", lat, 3);
        check("reg7f_bin", bif.bin_val, 1);
        check("reg7f_range", bif.cur_range, 472);
        check("reg7f_offset", bif.cur_offset, 53);
        check("reg7f_bits", bit_cnt - b0, 1);

        init_bits(9'b100101100);
        bif.bit_in = 1'b0;
        request(2'b00, 8'hC0);
        wait_bin(0, 0, lat);
        check("regc0_lat", lat, 2);
        check("regc0_bin", bif.bin_val, 1);
        check("regc0_range", bif.cur_range, 394);
        check("regc0_offset", bif.cur_offset, 300);

        init_bits(9'b111111100);
        check("init508_offset", bif.cur_offset, 508);
        request(2'b10, 8'h00);
        wait_bin(0, 0, lat);
        check("term1_lat", lat, 2);
        check("term1_bin", bif.bin_val, 1);
        check("term1_slice_end", bif.slice_end, 1);
        check("term1_range", bif.cur_range, 508);
        check("term1_req_ready", bif.req_ready, 0);
        check("term1_busy", bif.busy, 0);
        tick();
        check("term1_slice_end_pulse", bif.slice_end, 0);
        check("term1_idle_req_ready", bif.req_ready, 0);

        init_bits(9'b100101100);
        v0 = bv_cnt;
        bif.init = 1'b1;
        bif.req_valid = 1'b1;
        bif.req_mode = 2'b00;
        #1;
        check("coinc_req_ready", bif.req_ready, 0);
        tick();
        bif.init = 1'b0;
        bif.req_valid = 1'b0;
        check("coinc_bit_ready", bif.bit_ready, 1);
        check("coinc_busy", bif.busy, 1);
        feed_bits(9'b000000101);
        check("coinc_offset", bif.cur_offset, 5);
        check("coinc_req_ready", bif.req_ready, 1);
        check("coinc_no_bin", bv_cnt - v0, 0);

        init_bits(9'b100101100);
        v0 = bv_cnt;
        request(2'b00, 8'h7F);
        tick();
        check("renorm_bit_ready", bif.bit_ready, 1);
        check("renorm_range", bif.cur_range, 236);
        check("renorm_offset", bif.cur_offset, 26);
        b0 = bit_cnt;
        init_bits(9'b111111100);
        check("abort_offset", bif.cur_offset, 508);
        check("abort_range", bif.cur_range, 510);
        check("abort_bits", bit_cnt - b0, 9);
        check("abort_no_bin", bv_cnt - v0, 0);

        v0 = bv_cnt;
        bif.init = 1'b1;
        tick();
        bif.init = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bif.bit_in = 1'b1;
            bif.bit_valid = 1'b1;
            tick();
        end
        bif.bit_valid = 1'b0;
        check("part_offset", bif.cur_offset, 15);
        rst_n = 1'b0;
        #1;
        check("midrst_range", bif.cur_range, 510);
        check("midrst_offset", bif.cur_offset, 0);
        check("midrst_busy", bif.busy, 0);
        check("midrst_bit_ready", bif.bit_ready, 0);
        tick();
        tick();
        check("midrst_hold_offset", bif.cur_offset, 0);
        rst_n = 1'b1;
        tick();
        check("midrst_idle_busy", bif.busy, 0);
        init_bits(9'b100101100);
        check("reinit_offset", bif.cur_offset, 300);
        check("reinit_range", bif.cur_range, 510);
        check("reinit_req_ready", bif.req_ready, 1);
        check("reinit_no_bin", bv_cnt - v0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
